decode_regfile_sb: RTL
======================

Name: decode_regfile_sb

Overview:
- Parametrised successor to the decode-stage register file and load-use hazard unit.
- Provides a multi-read, single-write register file with same-cycle write-to-read bypass.
- Holds a per-register pending scoreboard that tracks long-latency producers (loads) of any latency. It raises a decode stall until the producing writeback arrives.
- Sits in ID. Writeback drives the write port; the ID control logic drives the issue interface and consumes stall.

Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, >=2)
- AW, $clog2(NREGS), register address width (derived, not overridden)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never marked pending
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- CNT_W, 16, width of the stall performance counter

Ports:
- clk, input, 1, clock; all state updates on posedge
- rst_n, input, 1, asynchronous active-low reset
- rd_addr, input, NRD*AW, read addresses; port i is bits [i*AW +: AW]
- rd_src_vld, input, NRD, read port i is a real source operand (participates in hazard check)
- rd_data, output, NRD*DATA_W, read data; port i is bits [i*DATA_W +: DATA_W]
- wr_en, input, 1, writeback write enable
- wr_addr, input, AW, writeback destination
- wr_data, input, DATA_W, writeback data
- issue_vld, input, 1, the instruction in ID is leaving ID this cycle if not stalled
- issue_long, input, 1, that instruction is a long-latency producer (load)
- issue_dst, input, AW, its destination register
- kill_en, input, 1, an in-flight long producer was squashed
- kill_addr, input, AW, destination of the squashed producer
- stall, output, 1, hold PC/IF and insert a bubble into EX
- pending, output, NREGS, scoreboard bit per register (registered)
- stall_cnt, output, CNT_W, saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers, pending and stall_cnt are cleared to 0
  - rd_data therefore reads 0 and stall reads 0
  - reset mid-operation discards all pending bits and counts immediately, without waiting for a clock edge
- Read:
  - combinational: rd_data[i] = reg[rd_addr[i]]
  - if BYPASS=1, wr_en=1 and wr_addr==rd_addr[i], rd_data[i] = wr_data
  - if ZERO_REG=1 and rd_addr[i]==0, rd_data[i] = 0 regardless of bypass
- Write:
  - reg[wr_addr] <= wr_data at posedge when wr_en=1
  - suppressed for address 0 when ZERO_REG=1
- Hazard:
  - port i is hazardous when rd_src_vld[i]=1, pending[rd_addr[i]]=1, and not (wr_en=1 and wr_addr==rd_addr[i])
  - stall = OR over all ports of hazardous; combinational, no added latency
  - with BYPASS=0 the wr_addr exemption is removed, which adds one stall cycle relative to BYPASS=1
- Scoreboard set: do_set = issue_vld and issue_long and not stall and not (ZERO_REG and issue_dst==0). On do_set, pending[issue_dst] <= 1.
- Scoreboard clear:
  - pending[wr_addr] <= 0 when wr_en=1
  - pending[kill_addr] <= 0 when kill_en=1
- Priority on the same register in the same cycle: set beats clear and kill (the new producer supersedes the old one); clear and kill together give 0. Different registers update independently in the same cycle.
- Clearing a bit that is not pending is a no-op.
- A second long producer to an already pending register keeps the bit at 1. The first writeback clears it, which is the same as the single-bit hazard behaviour in ID.
- When stall=1 the issue is not accepted: no set happens and the issuing side must hold its inputs.
- stall_cnt increments by 1 on each posedge with stall=1, and saturates at 2^CNT_W-1.
- pending 0 is constant 0 when ZERO_REG=1.

Test Plan:
- Reset, then read ports 0/1 at addr 5/31 -> rd_data=0, stall=0, pending=0, stall_cnt=0.
- Write 0xDEADBEEF to r7 with rd_addr[0]=7 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally (BYPASS=1); the next cycle with wr_en=0 still reads 0xDEADBEEF.
- Issue a load with issue_dst=9; the next cycle the instruction has rd_addr[1]=9 and rd_src_vld=2'b10 -> stall=1.
  - Hold for 3 cycles -> stall_cnt=3.
  - Writeback r9=0x1234 -> stall=0 that same cycle and rd_data[1]=0x1234.
- Load to r0 (ZERO_REG=1) -> pending stays 0; writing 0x55 to r0 and then reading r0 -> 0.
- In one cycle: issue a load to r4 while wr_en writes r4 -> pending[4]=1 after the edge (set wins).
  - Then kill_en with kill_addr=4 -> pending[4]=0.
- Pending r3 with rd_addr[0]=3 but rd_src_vld=0 -> stall=0.
- Assert rst_n=0 asynchronously mid-stall -> stall, pending and stall_cnt go to 0 before the next clock edge.

Source files
------------

// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with write-to-read bypass and a per-register
// pending scoreboard that stalls decode on long-latency (load) producers.
module decode_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    input  logic [NRD-1:0]        rd_src_vld,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  issue_vld,
    input  logic                  issue_long,
    input  logic [AW-1:0]         issue_dst,
    input  logic                  kill_en,
    input  logic [AW-1:0]         kill_addr,
    output logic                  stall,
    output logic [NREGS-1:0]      pending,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              stall_c;
    logic              do_set;
    logic [AW-1:0]     rd_a;
    logic [DATA_W-1:0] rd_v;
    logic              wr_hit;

    // Read ports and hazard detection; a writeback landing this cycle both
    // forwards its data and releases the hazard when bypass is enabled.
    always_comb begin
        rd_data = '0;
        stall_c = 1'b0;
        rd_a    = '0;
        rd_v    = '0;
        wr_hit  = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            rd_a   = rd_addr[p*AW +: AW];
            wr_hit = wr_en && (wr_addr == rd_a);
            rd_v   = regs_q[rd_a];
            if (BP && wr_hit) begin
                rd_v = wr_data;
            end
            if (ZR && (rd_a == '0)) begin
                rd_v = '0;
            end
            rd_data[p*DATA_W +: DATA_W] = rd_v;
            if (rd_src_vld[p] && pending_q[rd_a] && !(BP && wr_hit)) begin
                stall_c = 1'b1;
            end
        end
    end

    assign do_set = issue_vld && issue_long && !stall_c && !(ZR && (issue_dst == '0));

    always_comb begin
        regs_d      = regs_q;
        pending_d   = pending_q;
        stall_cnt_d = stall_cnt_q;
        for (int r = 0; r < NREGS; r++) begin
            if (wr_en && (wr_addr == AW'(r)) && !(ZR && (r == 0))) begin
                regs_d[r] = wr_data;
            end
        end
        if (wr_en) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (kill_en) begin
            pending_d[kill_addr] = 1'b0;
        end
        // Applied last: a new producer supersedes a same-cycle writeback/kill.
        if (do_set) begin
            pending_d[issue_dst] = 1'b1;
        end
        if (ZR) begin
            pending_d[0] = 1'b0;
        end
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            regs_q      <= regs_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_c;
    assign pending   = pending_q;
    assign stall_cnt = stall_cnt_q;

endmodule
